// File: rtl/cm0_rst_pkg.sv
// -----------------------------------------------------------------------------
// cm0_rst_pkg
// Shared definitions for the Cortex-M0 reset sequencer:
//   - state_t   : sequencer FSM states (IDLE / HOLD / RECOVER)
//   - CAUSE_*   : bit positions inside the sticky RSTCAUSE record
//   - CAUSE_W   : width of the RSTCAUSE record
// -----------------------------------------------------------------------------
package cm0_rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam int CAUSE_W      = 4;
    localparam int CAUSE_SYS    = 0;
    localparam int CAUSE_PMUH   = 1;
    localparam int CAUSE_PMUDBG = 2;
    localparam int CAUSE_LOCKUP = 3;

endpackage

// File: rtl/cm0_rst_cnt.sv
// -----------------------------------------------------------------------------
// cm0_rst_cnt
// Loadable down counter with a zero flag. Shared by the HOLD and RECOVER
// phases of the reset sequencer.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (has priority over dec)
//   dec      in   decrement by one; holds at zero
//   load_val in   value to load
//   count    out  current count
//   zero     out  count == 0
// -----------------------------------------------------------------------------
module cm0_rst_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cm0_rst_seq.sv
// -----------------------------------------------------------------------------
// cm0_rst_seq
// Reset sequencer for the Cortex-M0 integration reset path. Arbitrates
// system, PMU and (optionally) lockup reset requests into one sequence at a
// time: requests are held for HOLD_CYCLES, followed by a RECOVER_CYCLES quiet
// gap. A sticky cause record tells software what triggered resets.
//
// Optional feature macro: CM0_RST_SEQ_LOCKUP_EN
//   defined   : LOCKUP & LOCKUPRESETEN is an HRESET source, RSTCAUSE[3] live
//   undefined : LOCKUP/LOCKUPRESETEN ignored, RSTCAUSE[3] stays 0
//
// Request semantics: every request input is a level sampled on FCLK; there is
// no handshake. A level seen in IDLE (or on the last RECOVER cycle) starts a
// sequence; a level seen in HOLD joins the running sequence; a level seen
// only inside RECOVER is dropped.
//
// Ports:
//   FCLK            in   clock
//   PORESET         in   asynchronous active-high reset
//   SYSRESETREQ     in   system reset request (level)
//   PMUHRESETREQ    in   PMU HRESET request (level)
//   PMUDBGRESETREQ  in   PMU debug reset request (level)
//   LOCKUP          in   processor lockup indication (level)
//   LOCKUPRESETEN   in   enables lockup as a reset source
//   CAUSECLR        in   single-cycle pulse clearing RSTCAUSE
//   HRESETREQ       out  registered HRESETn request
//   DBGRESETREQ     out  registered DBGRESETn request
//   BUSY            out  registered, high in HOLD or RECOVER
//   RSTCAUSE        out  sticky cause {LOCKUP, PMUDBG, PMUH, SYS}
// -----------------------------------------------------------------------------
module cm0_rst_seq
    import cm0_rst_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int RECOVER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic               FCLK,
    input  logic               PORESET,
    input  logic               SYSRESETREQ,
    input  logic               PMUHRESETREQ,
    input  logic               PMUDBGRESETREQ,
    input  logic               LOCKUP,
    input  logic               LOCKUPRESETEN,
    input  logic               CAUSECLR,
    output logic               HRESETREQ,
    output logic               DBGRESETREQ,
    output logic               BUSY,
    output logic [CAUSE_W-1:0] RSTCAUSE
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LD  = CNT_W'(RECOVER_CYCLES - 1);

    // State is kept in a named register so checkers can bind to it.
    state_t state;
    state_t state_d;

    logic               lock_src;
    logic               hsrc;
    logic               dsrc;
    logic               any_src;
    logic [CAUSE_W-1:0] src_vec;

    logic               h_d;
    logic               d_d;
    logic               busy_d;
    logic [CAUSE_W-1:0] cause_set;
    logic [CAUSE_W-1:0] cause_d;

    logic               cnt_load;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_ld_val;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;

`ifdef CM0_RST_SEQ_LOCKUP_EN
    assign lock_src = LOCKUP & LOCKUPRESETEN;
`else
    logic unused_lockup;
    assign unused_lockup = LOCKUP | LOCKUPRESETEN;
    assign lock_src      = 1'b0;
`endif

    assign hsrc    = SYSRESETREQ | PMUHRESETREQ | lock_src;
    assign dsrc    = PMUDBGRESETREQ;
    assign any_src = hsrc | dsrc;

    always_comb begin
        src_vec               = '0;
        src_vec[CAUSE_SYS]    = SYSRESETREQ;
        src_vec[CAUSE_PMUH]   = PMUHRESETREQ;
        src_vec[CAUSE_PMUDBG] = PMUDBGRESETREQ;
        src_vec[CAUSE_LOCKUP] = lock_src;
    end

    cm0_rst_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (FCLK),
        .rst      (PORESET),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_ld_val),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        h_d        = HRESETREQ;
        d_d        = DBGRESETREQ;
        cause_set  = '0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_ld_val = HOLD_LD;

        case (state)
            IDLE: begin
                h_d = 1'b0;
                d_d = 1'b0;
                if (any_src) begin
                    state_d   = HOLD;
                    h_d       = hsrc;
                    d_d       = dsrc;
                    cause_set = src_vec;
                    cnt_load  = 1'b1;
                end
            end

            HOLD: begin
                if (cnt_zero) begin
                    // A request first seen on the final HOLD edge cannot join
                    // (the outputs drop now), so it is not recorded either.
                    state_d    = RECOVER;
                    h_d        = 1'b0;
                    d_d        = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_ld_val = REC_LD;
                end else begin
                    h_d       = HRESETREQ | hsrc;
                    d_d       = DBGRESETREQ | dsrc;
                    cause_set = src_vec;
                    cnt_dec   = 1'b1;
                end
            end

            RECOVER: begin
                if (cnt_zero) begin
                    // The last RECOVER edge samples like IDLE so a held
                    // request restarts after exactly RECOVER_CYCLES low cycles.
                    if (any_src) begin
                        state_d   = HOLD;
                        h_d       = hsrc;
                        d_d       = dsrc;
                        cause_set = src_vec;
                        cnt_load  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                h_d     = 1'b0;
                d_d     = 1'b0;
            end
        endcase

        // A set in the same cycle as CAUSECLR survives; everything else clears.
        cause_d = CAUSECLR ? cause_set : (RSTCAUSE | cause_set);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge FCLK or posedge PORESET) begin
        if (PORESET) begin
            state       <= IDLE;
            HRESETREQ   <= 1'b0;
            DBGRESETREQ <= 1'b0;
            BUSY        <= 1'b0;
            RSTCAUSE    <= '0;
        end else begin
            state       <= state_d;
            HRESETREQ   <= h_d;
            DBGRESETREQ <= d_d;
            BUSY        <= busy_d;
            RSTCAUSE    <= cause_d;
        end
    end

endmodule

// File: tb/tb_cm0_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_cm0_rst_seq
// Directed bench for cm0_rst_seq with default parameters (HOLD=16, RECOVER=4).
// The driver pushes the expected outcome of each reset sequence into exp_q
// (pulse widths, cause, preceding gap) and the expected BUSY run length into
// busy_q. A negedge monitor measures every request pulse and BUSY run and
// compares against the queues.
// -----------------------------------------------------------------------------
module tb_cm0_rst_seq;
    import cm0_rst_pkg::*;

    localparam int REC_W = 28;   // {h_cycles[7:0], d_cycles[7:0], cause[3:0], gap[7:0]}

    logic       FCLK;
    logic       PORESET;
    logic       SYSRESETREQ;
    logic       PMUHRESETREQ;
    logic       PMUDBGRESETREQ;
    logic       LOCKUP;
    logic       LOCKUPRESETEN;
    logic       CAUSECLR;
    logic       HRESETREQ;
    logic       DBGRESETREQ;
    logic       BUSY;
    logic [3:0] RSTCAUSE;

    logic [REC_W-1:0] exp_q[$];
    logic [7:0]       busy_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    cm0_rst_seq dut (
        .FCLK           (FCLK),
        .PORESET        (PORESET),
        .SYSRESETREQ    (SYSRESETREQ),
        .PMUHRESETREQ   (PMUHRESETREQ),
        .PMUDBGRESETREQ (PMUDBGRESETREQ),
        .LOCKUP         (LOCKUP),
        .LOCKUPRESETEN  (LOCKUPRESETEN),
        .CAUSECLR       (CAUSECLR),
        .HRESETREQ      (HRESETREQ),
        .DBGRESETREQ    (DBGRESETREQ),
        .BUSY           (BUSY),
        .RSTCAUSE       (RSTCAUSE)
    );

    // ---------------- clock / watchdog ----------------
    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [REC_W-1:0] mk_rec(input int h, input int d,
                                                input logic [3:0] c, input int g);
        mk_rec = {8'(h), 8'(d), c, 8'(g)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n active edges and land 1ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge FCLK);
        #1;
    endtask

    task automatic pulse_clr();
        CAUSECLR = 1'b1;
        tick(1);
        CAUSECLR = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       prev_act  = 1'b0;
    logic       prev_busy = 1'b0;
    int         h_cnt     = 0;
    int         d_cnt     = 0;
    int         gap_cnt   = 255;
    int         gap_seen  = 0;
    int         busy_len  = 0;

    always @(negedge FCLK) begin
        logic             act;
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] want;
        act = HRESETREQ | DBGRESETREQ;
        if (PORESET) begin
            prev_act  = 1'b0;
            prev_busy = 1'b0;
            h_cnt     = 0;
            d_cnt     = 0;
            gap_cnt   = 255;
            busy_len  = 0;
        end else begin
            // request pulse tracking
            if (act) begin
                if (!prev_act) gap_seen = gap_cnt;
                h_cnt += int'(HRESETREQ);
                d_cnt += int'(DBGRESETREQ);
            end else if (prev_act) begin
                got = mk_rec(h_cnt, d_cnt, RSTCAUSE, gap_seen);
                if (exp_q.size() == 0) begin
                    check("unexpected_seq", 32'(got), 32'(0));
                end else begin
                    want = exp_q.pop_front();
                    if (want[7:0] == 8'd0) got[7:0] = 8'd0;  // gap don't-care
                    check("seq_record", 32'(got), 32'(want));
                end
                h_cnt   = 0;
                d_cnt   = 0;
                gap_cnt = 1;
            end else if (gap_cnt < 255) begin
                gap_cnt++;
            end
            prev_act = act;

            // BUSY run tracking
            if (BUSY) begin
                busy_len++;
            end else if (prev_busy) begin
                if (busy_q.size() == 0) begin
                    check("unexpected_busy", 32'(busy_len), 32'(0));
                end else begin
                    check("busy_len", 32'(busy_len), 32'(busy_q.pop_front()));
                end
                busy_len = 0;
            end
            prev_busy = BUSY;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        PORESET        = 1'b1;
        SYSRESETREQ    = 1'b0;
        PMUHRESETREQ   = 1'b0;
        PMUDBGRESETREQ = 1'b0;
        LOCKUP         = 1'b0;
        LOCKUPRESETEN  = 1'b0;
        CAUSECLR       = 1'b0;
        tick(3);
        PORESET = 1'b0;
        tick(2);

        // reset state
        check("rst_hreq",  32'(HRESETREQ),   32'(0));
        check("rst_dreq",  32'(DBGRESETREQ), 32'(0));
        check("rst_busy",  32'(BUSY),        32'(0));
        check("rst_cause", 32'(RSTCAUSE),    32'(0));
        check("rst_state", 32'(dut.state),   32'(IDLE));

        // 1: one-cycle SYS pulse
        exp_q.push_back(mk_rec(16, 0, 4'b0001, 0));
        busy_q.push_back(8'd20);
        SYSRESETREQ = 1'b1;
        tick(1);
        SYSRESETREQ = 1'b0;
        check("sys_first_cycle_hreq", 32'(HRESETREQ), 32'(1));
        check("sys_first_cycle_busy", 32'(BUSY),      32'(1));
        tick(25);
        check("sys_cause", 32'(RSTCAUSE), 32'(4'b0001));

        // 2: PMUDBG alone
        pulse_clr();
        check("clr_alone", 32'(RSTCAUSE), 32'(0));
        exp_q.push_back(mk_rec(0, 16, 4'b0100, 0));
        busy_q.push_back(8'd20);
        PMUDBGRESETREQ = 1'b1;
        tick(1);
        PMUDBGRESETREQ = 1'b0;
        tick(25);
        check("dbg_cause", 32'(RSTCAUSE), 32'(4'b0100));

        // 3: SYS held for three back-to-back sequences
        pulse_clr();
        exp_q.push_back(mk_rec(16, 0, 4'b0001, 0));
        exp_q.push_back(mk_rec(16, 0, 4'b0001, 4));
        exp_q.push_back(mk_rec(16, 0, 4'b0001, 4));
        busy_q.push_back(8'd60);
        SYSRESETREQ = 1'b1;
        tick(41);
        SYSRESETREQ = 1'b0;
        tick(30);

        // 4: PMUH joins at HOLD cycle 5, SYS pulse in RECOVER ignored
        pulse_clr();
        exp_q.push_back(mk_rec(16, 0, 4'b0011, 0));
        busy_q.push_back(8'd20);
        SYSRESETREQ = 1'b1;
        tick(1);
        SYSRESETREQ = 1'b0;
        tick(4);
        PMUHRESETREQ = 1'b1;
        tick(1);
        PMUHRESETREQ = 1'b0;
        tick(12);
        SYSRESETREQ = 1'b1;
        tick(1);
        SYSRESETREQ = 1'b0;
        tick(20);
        check("join_cause", 32'(RSTCAUSE), 32'(4'b0011));
        check("join_idle",  32'(BUSY),     32'(0));

        // 5: lockup with and without enable
        pulse_clr();
        LOCKUP = 1'b1;
        tick(5);
        check("lockup_dis_busy",  32'(BUSY),     32'(0));
        check("lockup_dis_cause", 32'(RSTCAUSE), 32'(0));
`ifdef CM0_RST_SEQ_LOCKUP_EN
        exp_q.push_back(mk_rec(16, 0, 4'b1000, 0));
        busy_q.push_back(8'd20);
`endif
        LOCKUPRESETEN = 1'b1;
        tick(1);
        LOCKUP        = 1'b0;
        LOCKUPRESETEN = 1'b0;
        tick(2);
`ifdef CM0_RST_SEQ_LOCKUP_EN
        check("lockup_en_busy",  32'(BUSY),     32'(1));
        check("lockup_en_cause", 32'(RSTCAUSE), 32'(4'b1000));
`else
        check("lockup_en_busy",  32'(BUSY),     32'(0));
        check("lockup_en_cause", 32'(RSTCAUSE), 32'(0));
`endif
        tick(25);

        // 6: PORESET mid-HOLD aborts asynchronously
        SYSRESETREQ = 1'b1;
        tick(1);
        SYSRESETREQ = 1'b0;
        tick(5);
        check("hold_before_por", 32'(HRESETREQ), 32'(1));
        #2;
        PORESET = 1'b1;
        #1;
        check("por_hreq",  32'(HRESETREQ),   32'(0));
        check("por_dreq",  32'(DBGRESETREQ), 32'(0));
        check("por_busy",  32'(BUSY),        32'(0));
        check("por_cause", 32'(RSTCAUSE),    32'(0));
        tick(1);
        PORESET = 1'b0;
        tick(2);
        check("post_por_state", 32'(dut.state), 32'(IDLE));
        check("post_por_hreq",  32'(HRESETREQ), 32'(0));
        check("post_por_busy",  32'(BUSY),      32'(0));

        // 7: CAUSECLR coincident with a new SYS request
        exp_q.push_back(mk_rec(0, 16, 4'b0100, 0));
        busy_q.push_back(8'd20);
        PMUDBGRESETREQ = 1'b1;
        tick(1);
        PMUDBGRESETREQ = 1'b0;
        tick(25);
        check("pre_clr_cause", 32'(RSTCAUSE), 32'(4'b0100));
        exp_q.push_back(mk_rec(16, 0, 4'b0001, 0));
        busy_q.push_back(8'd20);
        SYSRESETREQ = 1'b1;
        CAUSECLR    = 1'b1;
        tick(1);
        SYSRESETREQ = 1'b0;
        CAUSECLR    = 1'b0;
        check("clr_set_cause", 32'(RSTCAUSE), 32'(4'b0001));
        tick(30);

        // every expected sequence must have been observed
        check("seq_q_empty",  32'(exp_q.size()),  32'(0));
        check("busy_q_empty", 32'(busy_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
